// File: rtl/clk_enable_gen_if.sv
// Divisor-update handshake bundle: the requester drives valid/ch/div, the divider answers with ready.
interface clk_enable_gen_if #(
    parameter int CNT_W = 8,
    parameter int CH_W  = 1
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable / divided-clock generator with shadowed, period-aligned divisor updates.
// tick is combinational from state; clk_out is registered; cfg_ready stalls while the target channel has an update queued.
module clk_enable_gen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_CH-1:0]  en,
    clk_enable_gen_if.slave    cfg,
    output logic [NUM_CH-1:0]  tick,
    output logic [NUM_CH-1:0]  clk_out,
    output logic [NUM_CH-1:0]  pending
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic             RST_CLK = (DEFAULT_DIV == 1);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_CH-1:0][CNT_W-1:0] div_q;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] div_d;
    logic [NUM_CH-1:0][CNT_W-1:0] shadow_d;
    logic [NUM_CH-1:0]            clk_d;
    logic [NUM_CH-1:0]            pending_d;
    logic [NUM_CH-1:0]            apply;
    logic [NUM_CH-1:0]            hit;
    logic                         ready;
    logic                         cfg_fire;
    logic [CNT_W-1:0]             new_div;

    // Out-of-range channels always accept so a stray write can never stall the requester.
    always_comb begin
        ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                ready = ~pending[i];
            end
        end
    end

    assign cfg.cfg_ready = ready;
    assign cfg_fire      = cfg.cfg_valid & ready;
    assign new_div       = (cfg.cfg_div == '0) ? CNT_W'(1) : cfg.cfg_div;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = cfg_fire & (cfg.cfg_ch == CH_W'(i));
        end
    end

    // A channel that accepts a write has pending low that cycle, so apply and accept never
    // coincide: a write landing in a tick cycle waits for the following wrap.
    always_comb begin
        tick      = '0;
        apply     = '0;
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        clk_d     = '0;
        pending_d = pending;
        for (int i = 0; i < NUM_CH; i++) begin
            tick[i]  = en[i] & (cnt_q[i] == div_q[i] - CNT_W'(1));
            apply[i] = pending[i] & (~en[i] | tick[i]);

            if (apply[i]) begin
                div_d[i] = shadow_q[i];
                cnt_d[i] = '0;
            end else if (en[i]) begin
                cnt_d[i] = tick[i] ? '0 : cnt_q[i] + CNT_W'(1);
            end

            clk_d[i] = (cnt_d[i] >= (div_d[i] >> 1));

            if (hit[i]) begin
                shadow_d[i] = new_div;
            end
            pending_d[i] = hit[i] | (pending[i] & ~apply[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            div_q    <= {NUM_CH{DEF_DIV}};
            shadow_q <= {NUM_CH{DEF_DIV}};
            pending  <= '0;
            clk_out  <= {NUM_CH{RST_CLK}};
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pending  <= pending_d;
            clk_out  <= clk_d;
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed vector bench for clk_enable_gen: a 2-channel instance driven from a per-cycle table,
// plus a 3-channel instance for the out-of-range channel write.
module tb_clk_enable_gen;

    typedef struct {
        logic       rst;
        logic [1:0] en;
        logic       v;
        logic       ch;
        logic [7:0] div;
        logic [1:0] e_tick;
        logic [1:0] e_clk;
        logic [1:0] e_pend;
        logic       e_rdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rst3;
    logic [1:0] en;
    logic [2:0] en3;
    logic [1:0] tick, clk_out, pending;
    logic [2:0] tick3, clk_out3, pending3;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    clk_enable_gen_if #(.CNT_W(8), .CH_W(1)) cfg_a ();
    clk_enable_gen_if #(.CNT_W(8), .CH_W(2)) cfg_b ();

    clk_enable_gen #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .cfg     (cfg_a),
        .tick    (tick),
        .clk_out (clk_out),
        .pending (pending)
    );

    clk_enable_gen #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut3 (
        .clk     (clk),
        .reset   (rst3),
        .en      (en3),
        .cfg     (cfg_b),
        .tick    (tick3),
        .clk_out (clk_out3),
        .pending (pending3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] e, input logic v, input logic c,
                                input logic [7:0] d, input logic [1:0] t, input logic [1:0] k,
                                input logic [1:0] p, input logic y);
        vec_t x;
        x.rst = r; x.en = e; x.v = v; x.ch = c; x.div = d;
        x.e_tick = t; x.e_clk = k; x.e_pend = p; x.e_rdy = y;
        return x;
    endfunction

    initial begin
        logic [2:0] exp_tick3;
        logic [2:0] exp_clk3;

        //                  rst en v ch div  tick clk pend rdy
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 0, 0, 1)); // c0 default D=4
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   3, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 3, 1, 1, 3,   0, 0, 0, 1)); // c5 ch1 <- 3
        vecs.push_back(mk(0, 3, 0, 1, 0,   0, 3, 2, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0,   3, 3, 2, 0)); // applies after this tick
        vecs.push_back(mk(0, 3, 0, 1, 0,   0, 0, 0, 1)); // c8 ch1 D=3
        vecs.push_back(mk(0, 3, 0, 1, 0,   0, 2, 0, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0,   2, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0,   1, 1, 0, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0,   0, 2, 0, 1));
        vecs.push_back(mk(0, 3, 1, 0, 0,   2, 2, 0, 1)); // c13 ch0 <- 0 (means 1)
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 1, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0,   1, 3, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0,   3, 3, 0, 1)); // c16 ch0 D=1
        vecs.push_back(mk(0, 3, 1, 0, 1,   1, 1, 0, 1)); // c17 ch0 <- 1
        vecs.push_back(mk(0, 3, 0, 0, 0,   1, 3, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0,   3, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   1, 1, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   1, 3, 0, 1));
        vecs.push_back(mk(0, 3, 1, 1, 5,   3, 3, 0, 1)); // c22 ch1 <- 5 in its tick cycle
        vecs.push_back(mk(0, 3, 0, 1, 0,   1, 1, 2, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0,   1, 3, 2, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0,   3, 3, 2, 0)); // applied at this later wrap
        vecs.push_back(mk(0, 3, 0, 1, 0,   1, 1, 0, 1)); // c26 ch1 D=5
        vecs.push_back(mk(0, 3, 0, 1, 0,   1, 1, 0, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0,   1, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0,   1, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0,   3, 3, 0, 1));
        vecs.push_back(mk(0, 3, 1, 0, 4,   1, 1, 0, 1)); // c31 ch0 <- 4
        vecs.push_back(mk(0, 3, 0, 0, 0,   1, 1, 1, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 2, 0, 1)); // c33 ch0 D=4 cnt0
        vecs.push_back(mk(0, 2, 0, 0, 0,   0, 2, 0, 1)); // c34 en0 low at cnt1
        vecs.push_back(mk(0, 2, 0, 0, 0,   2, 2, 0, 1));
        vecs.push_back(mk(0, 2, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 2, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 2, 0, 0, 0,   0, 2, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 2, 0, 1)); // c39 en0 back
        vecs.push_back(mk(0, 3, 0, 0, 0,   2, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   1, 1, 0, 1)); // tick two cycles after re-enable
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 2, 1, 0, 6,   0, 2, 0, 1)); // c43 en0 low, ch0 <- 6
        vecs.push_back(mk(0, 2, 0, 0, 0,   0, 2, 1, 0));
        vecs.push_back(mk(0, 2, 0, 0, 0,   2, 2, 0, 1)); // applied at next edge
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 0, 0, 1)); // c46 ch0 D=6
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 2, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   0, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   2, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 0, 0,   1, 1, 0, 1));
        vecs.push_back(mk(0, 3, 1, 1, 7,   0, 0, 0, 1)); // c52 ch1 <- 7
        vecs.push_back(mk(1, 3, 0, 1, 0,   0, 2, 2, 0)); // c53 reset with ch1 pending
        vecs.push_back(mk(0, 3, 0, 1, 0,   0, 0, 0, 1)); // c54 both back to D=4
        vecs.push_back(mk(0, 3, 0, 1, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0,   0, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0,   3, 3, 0, 1));
        vecs.push_back(mk(0, 3, 0, 1, 0,   0, 0, 0, 1));

        reset = 1'b1;
        rst3  = 1'b1;
        en    = '0;
        en3   = '0;
        cfg_a.cfg_valid = 1'b0;
        cfg_a.cfg_ch    = '0;
        cfg_a.cfg_div   = '0;
        cfg_b.cfg_valid = 1'b0;
        cfg_b.cfg_ch    = '0;
        cfg_b.cfg_div   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_tick",    0, 8'(tick),            8'h0);
        check("rst_clk_out", 0, 8'(clk_out),         8'h0);
        check("rst_pending", 0, 8'(pending),         8'h0);
        check("rst_ready",   0, 8'(cfg_a.cfg_ready), 8'h1);

        for (int k = 0; k < vecs.size(); k++) begin
            reset           = vecs[k].rst;
            en              = vecs[k].en;
            cfg_a.cfg_valid = vecs[k].v;
            cfg_a.cfg_ch    = vecs[k].ch;
            cfg_a.cfg_div   = vecs[k].div;
            @(negedge clk);
            check("tick",      k, 8'(tick),            8'(vecs[k].e_tick));
            check("clk_out",   k, 8'(clk_out),         8'(vecs[k].e_clk));
            check("pending",   k, 8'(pending),         8'(vecs[k].e_pend));
            check("cfg_ready", k, 8'(cfg_a.cfg_ready), 8'(vecs[k].e_rdy));
            @(posedge clk);
            #1;
        end
        cfg_a.cfg_valid = 1'b0;

        // 3-channel instance: a write to channel 3 is accepted and dropped
        check("rst3_pending", 0, 8'(pending3), 8'h0);
        check("rst3_clk_out", 0, 8'(clk_out3), 8'h0);
        rst3 = 1'b0;
        en3  = 3'b111;
        for (int k = 0; k < 8; k++) begin
            cfg_b.cfg_valid = (k == 0);
            cfg_b.cfg_ch    = 2'd3;
            cfg_b.cfg_div   = 8'd7;
            exp_tick3 = ((k % 4) == 3) ? 3'b111 : 3'b000;
            exp_clk3  = ((k % 4) >= 2) ? 3'b111 : 3'b000;
            @(negedge clk);
            check("oor_ready",   k, 8'(cfg_b.cfg_ready), 8'h1);
            check("oor_pending", k, 8'(pending3),        8'h0);
            check("oor_tick",    k, 8'(tick3),           8'(exp_tick3));
            check("oor_clk_out", k, 8'(clk_out3),        8'(exp_clk3));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
